// File: rtl/mesh_nic_fifo_if.sv
// CPU register port and router PE port of the mesh NIC, grouped as one bundle.
// master = CPU/router side, slave = NIC.
interface mesh_nic_fifo_if #(
  parameter int PACKET_WIDTH = 64
) ();
  logic [1:0]              addr;
  logic [PACKET_WIDTH-1:0] d_in;
  logic [PACKET_WIDTH-1:0] d_out;
  logic                    nicEn;
  logic                    nicEnWR;
  logic                    net_si;
  logic                    net_ri;
  logic [PACKET_WIDTH-1:0] net_di;
  logic                    net_so;
  logic                    net_ro;
  logic [PACKET_WIDTH-1:0] net_do;
  logic                    net_polarity;

  modport master (
    output addr, d_in, nicEn, nicEnWR, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );

  modport slave (
    input  addr, d_in, nicEn, nicEnWR, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/mesh_nic_fifo.sv
// Mesh NIC with DEPTH-deep ingress/egress FIFOs; CPU reads are combinational, router accept/send at posedge.
// Backpressure: net_ri drops when ingress is full; egress waits for net_ro and matching polarity.
module mesh_nic_fifo #(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4
) (
  input  logic           clk,
  input  logic           reset,
  mesh_nic_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [PACKET_WIDTH-1:0] ing_mem [DEPTH];
  logic [AW-1:0]           ing_wr_ptr, ing_rd_ptr;
  logic [CW-1:0]           ing_count;
  logic                    ing_underflow;

  logic [PACKET_WIDTH-1:0] egr_mem [DEPTH];
  logic [AW-1:0]           egr_wr_ptr, egr_rd_ptr;
  logic [CW-1:0]           egr_count;
  logic                    egr_overflow;

  logic ing_nonempty, ing_full, egr_nonempty, egr_full;
  logic cpu_rd, cpu_wr;
  logic ing_push, ing_pop_req, ing_pop, ing_uf_set, ing_st_rd;
  logic egr_push_req, egr_push, egr_pop, egr_ovf_set, egr_st_rd;
  logic [PACKET_WIDTH-1:0] ing_head, egr_head;

  assign ing_nonempty = (ing_count != '0);
  assign ing_full     = (ing_count == CW'(DEPTH));
  assign egr_nonempty = (egr_count != '0);
  assign egr_full     = (egr_count == CW'(DEPTH));
  assign ing_head     = ing_mem[ing_rd_ptr];
  assign egr_head     = egr_mem[egr_rd_ptr];

  assign cpu_rd = bus.nicEn & ~bus.nicEnWR;
  assign cpu_wr = bus.nicEn &  bus.nicEnWR;

  assign bus.net_ri = ~ing_full;
  assign ing_push    = bus.net_si & ~ing_full;
  assign ing_pop_req = cpu_rd & (bus.addr == 2'b00);
  assign ing_pop     = ing_pop_req & ing_nonempty;
  assign ing_uf_set  = ing_pop_req & ~ing_nonempty;
  assign ing_st_rd   = cpu_rd & (bus.addr == 2'b01);

  assign egr_push_req = cpu_wr & (bus.addr == 2'b10);
  assign egr_push     = egr_push_req & ~egr_full;
  assign egr_ovf_set  = egr_push_req & egr_full;
  assign egr_st_rd    = cpu_rd & (bus.addr == 2'b11);

  // Only the packet whose VC bit matches the router's current polarity may leave.
  assign bus.net_so = egr_nonempty & bus.net_ro & (egr_head[PACKET_WIDTH-1] == bus.net_polarity);
  assign egr_pop    = bus.net_so;
  assign bus.net_do = egr_nonempty ? egr_head : '0;

  always_comb begin
    bus.d_out = '0;
    case (bus.addr)
      2'b00:   bus.d_out = ing_nonempty ? ing_head : '0;
      2'b01:   bus.d_out = {{(PACKET_WIDTH-CW-2){1'b0}}, ing_underflow, ing_count, ing_nonempty};
      2'b11:   bus.d_out = {{(PACKET_WIDTH-CW-2){1'b0}}, egr_overflow, egr_count, egr_full};
      default: bus.d_out = '0;
    endcase
  end

  // Storage arrays carry no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    if (ing_push) ing_mem[ing_wr_ptr] <= bus.net_di;
    if (egr_push) egr_mem[egr_wr_ptr] <= bus.d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ing_wr_ptr    <= '0;
      ing_rd_ptr    <= '0;
      ing_count     <= '0;
      ing_underflow <= 1'b0;
      egr_wr_ptr    <= '0;
      egr_rd_ptr    <= '0;
      egr_count     <= '0;
      egr_overflow  <= 1'b0;
    end else begin
      if (ing_push) ing_wr_ptr <= ing_wr_ptr + 1'b1;
      if (ing_pop)  ing_rd_ptr <= ing_rd_ptr + 1'b1;
      case ({ing_push, ing_pop})
        2'b10:   ing_count <= ing_count + CW'(1);
        2'b01:   ing_count <= ing_count - CW'(1);
        default: ing_count <= ing_count;
      endcase

      if (egr_push) egr_wr_ptr <= egr_wr_ptr + 1'b1;
      if (egr_pop)  egr_rd_ptr <= egr_rd_ptr + 1'b1;
      case ({egr_push, egr_pop})
        2'b10:   egr_count <= egr_count + CW'(1);
        2'b01:   egr_count <= egr_count - CW'(1);
        default: egr_count <= egr_count;
      endcase

      // A new error in the same cycle as the status read keeps the flag set.
      if (ing_uf_set)     ing_underflow <= 1'b1;
      else if (ing_st_rd) ing_underflow <= 1'b0;
      if (egr_ovf_set)    egr_overflow  <= 1'b1;
      else if (egr_st_rd) egr_overflow  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mesh_nic_fifo.sv
// Scoreboard bench for mesh_nic_fifo: expected packets queued at drive time, compared on CPU pop / net_so.
module tb_mesh_nic_fifo;
  localparam int PW = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;

  logic [PW-1:0] ing_q[$];
  logic [PW-1:0] egr_q[$];

  mesh_nic_fifo_if #(.PACKET_WIDTH(PW)) bus ();
  mesh_nic_fifo #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] st(input bit flag, input int cnt, input bit b0);
    return PW'((int'(flag) << 4) | (cnt << 1) | int'(b0));
  endfunction

  task automatic cpu_read(input logic [1:0] a, output logic [PW-1:0] data);
    @(negedge clk);
    bus.nicEn = 1'b1; bus.nicEnWR = 1'b0; bus.addr = a;
    #1 data = bus.d_out;
    @(posedge clk);
    #1 bus.nicEn = 1'b0;
  endtask

  task automatic cpu_pop_check(input string tag);
    logic [PW-1:0] d;
    cpu_read(2'b00, d);
    if (ing_q.size() == 0) check(tag, d, '0);
    else check(tag, d, ing_q.pop_front());
  endtask

  task automatic cpu_push(input logic [PW-1:0] v);
    @(negedge clk);
    bus.nicEn = 1'b1; bus.nicEnWR = 1'b1; bus.addr = 2'b10; bus.d_in = v;
    @(posedge clk);
    if (egr_q.size() < DEPTH) egr_q.push_back(v);
    #1 bus.nicEn = 1'b0; bus.nicEnWR = 1'b0;
  endtask

  task automatic router_push(input logic [PW-1:0] v, input string tag);
    @(negedge clk);
    bus.net_si = 1'b1; bus.net_di = v;
    #1 check(tag, PW'(bus.net_ri), PW'(ing_q.size() < DEPTH));
    @(posedge clk);
    if (ing_q.size() < DEPTH) ing_q.push_back(v);
    #1 bus.net_si = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] d;
    bit exp_so;
    bus.addr = '0; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicEnWR = 1'b0;
    bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state
    check("rst_net_ri", PW'(bus.net_ri), PW'(1));
    check("rst_net_so", PW'(bus.net_so), PW'(0));
    check("rst_net_do", bus.net_do, '0);
    cpu_read(2'b01, d); check("rst_st01", d, '0);
    cpu_read(2'b11, d); check("rst_st11", d, '0);

    // 2: fill ingress, drain in order, underflow on extra pop
    for (int i = 1; i <= 4; i++) router_push(PW'(i), "ing_ri_fill");
    router_push(PW'(5), "ing_ri_full");
    cpu_read(2'b01, d); check("ing_st_full", d, st(0, 4, 1));
    for (int i = 0; i < 5; i++) cpu_pop_check("ing_pop");
    cpu_read(2'b01, d); check("ing_underflow", d, st(1, 0, 0));
    cpu_read(2'b01, d); check("ing_uf_clear", d, st(0, 0, 0));

    // 3: egress overflow with router stalled
    for (int i = 1; i <= 5; i++) cpu_push({1'b1, 55'd0, 8'(8'h10 + i)});
    #1 check("egr_so_stalled", PW'(bus.net_so), PW'(0));
    cpu_read(2'b11, d); check("egr_ovf", d, st(1, 4, 1));
    cpu_read(2'b11, d); check("egr_ovf_clear", d, st(0, 4, 1));
    cpu_read(2'b10, d); check("rd_addr10", d, '0);

    // 4: send only in polarity-1 cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.net_ro = 1'b1; bus.net_polarity = c[0];
      exp_so = (egr_q.size() != 0) && (egr_q[0][PW-1] == c[0]);
      #1 check("egr_net_so", PW'(bus.net_so), PW'(exp_so));
      if (exp_so) check("egr_net_do", bus.net_do, egr_q.pop_front());
      else if (egr_q.size() == 0) check("egr_do_empty", bus.net_do, '0);
    end
    @(negedge clk) bus.net_ro = 1'b0;
    cpu_read(2'b11, d); check("egr_drained", d, st(0, 0, 0));

    // 5: simultaneous router push and CPU pop at count 2
    router_push(PW'('hA1), "sim_fill");
    router_push(PW'('hA2), "sim_fill");
    @(negedge clk);
    bus.net_si = 1'b1; bus.net_di = PW'('hA3);
    bus.nicEn = 1'b1; bus.nicEnWR = 1'b0; bus.addr = 2'b00;
    #1 check("sim_pop", bus.d_out, ing_q.pop_front());
    @(posedge clk);
    ing_q.push_back(PW'('hA3));
    #1 bus.net_si = 1'b0; bus.nicEn = 1'b0;
    cpu_read(2'b01, d); check("sim_count", d, st(0, 2, 1));
    cpu_pop_check("sim_order");
    cpu_pop_check("sim_order");

    // 6: asynchronous reset with both FIFOs half-full
    router_push(PW'('hB1), "rst_fill");
    router_push(PW'('hB2), "rst_fill");
    cpu_push({1'b1, 63'h0C1});
    cpu_push({1'b1, 63'h0C2});
    @(negedge clk);
    bus.net_ro = 1'b1; bus.net_polarity = 1'b1;
    #1 check("pre_rst_so", PW'(bus.net_so), PW'(1));
    #1 reset = 1'b1;
    #1 check("async_rst_so", PW'(bus.net_so), PW'(0));
    check("async_rst_do", bus.net_do, '0);
    check("async_rst_ri", PW'(bus.net_ri), PW'(1));
    ing_q.delete(); egr_q.delete();
    @(posedge clk);
    #1 reset = 1'b0; bus.net_ro = 1'b0;
    cpu_read(2'b01, d); check("post_rst_st01", d, '0);
    cpu_read(2'b11, d); check("post_rst_st11", d, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
